// File: rtl/rv32i_types.sv
// Shared pipeline-control types: controller FSM states and the per-stage load/flush bundle.
package rv32i_types;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    IF_DRAIN = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic pc_load;
    logic if_id_load;
    logic if_id_flush;
    logic id_ex_load;
    logic id_ex_flush;
    logic ex_mem_load;
    logic ex_mem_flush;
    logic mem_wb_load;
    logic mem_wb_flush;
  } pipe_ctrl_t;

  // A flush only takes effect together with its load, so every flush bit below pairs with load=1.
  localparam pipe_ctrl_t CTRL_HOLD      = 9'b0_00_00_00_00;
  localparam pipe_ctrl_t CTRL_RUN       = 9'b1_10_10_10_10;
  localparam pipe_ctrl_t CTRL_MD_BUBBLE = 9'b0_00_00_00_11;
  localparam pipe_ctrl_t CTRL_REDIRECT  = 9'b1_11_11_10_10;
  localparam pipe_ctrl_t CTRL_IF_STALL  = 9'b0_11_10_10_10;
  localparam pipe_ctrl_t CTRL_LOAD_USE  = 9'b0_00_11_10_10;

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter with enable and synchronous clear; wraps modulo 2^WIDTH.
module perf_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: per-stage load/flush generation, mul/div and
// fetch-drain waits, a sticky pending redirect, and stall/flush performance counters.
module pipeline_ctrl
  import rv32i_types::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 imem_req,
  input  logic                 imem_resp,
  input  logic                 dmem_req,
  input  logic                 dmem_resp,
  input  logic                 load_use,
  input  logic                 redirect,
  input  logic                 md_start,
  input  logic                 md_done,
  output logic                 pc_load,
  output logic                 if_id_load,
  output logic                 if_id_flush,
  output logic                 id_ex_load,
  output logic                 id_ex_flush,
  output logic                 ex_mem_load,
  output logic                 ex_mem_flush,
  output logic                 mem_wb_load,
  output logic                 mem_wb_flush,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_events
);

  ctrl_state_t r_state;
  ctrl_state_t w_state_next;
  logic        r_redirect_pending;
  pipe_ctrl_t  w_ctrl;
  logic        w_mem_stall;
  logic        w_if_stall;
  logic        w_redir;
  logic        w_apply_redir;
  logic        w_run_eval;
  logic        w_md_check;

  assign w_mem_stall = dmem_req & ~dmem_resp;
  assign w_if_stall  = imem_req & ~imem_resp;
  assign w_redir     = redirect | r_redirect_pending;

  always_comb begin
    w_ctrl        = CTRL_HOLD;
    w_state_next  = r_state;
    w_apply_redir = 1'b0;
    w_run_eval    = 1'b0;
    w_md_check    = 1'b0;
    case (r_state)
      RUN: begin
        w_run_eval = 1'b1;
        w_md_check = 1'b1;
      end
      MD_WAIT: begin
        // On completion the RUN rules apply this same cycle, minus the mul/div check.
        if (md_done) begin
          w_run_eval = 1'b1;
        end else if (!w_mem_stall) begin
          w_ctrl = CTRL_MD_BUBBLE;
        end
      end
      IF_DRAIN: begin
        if (imem_resp && !w_mem_stall) begin
          w_ctrl        = CTRL_REDIRECT;
          w_apply_redir = 1'b1;
          w_state_next  = RUN;
        end
      end
      default: w_state_next = RUN;
    endcase

    if (w_run_eval) begin
      w_state_next = RUN;
      if (w_mem_stall) begin
        w_ctrl = CTRL_HOLD;
      end else if (w_md_check && md_start && !md_done) begin
        w_ctrl       = CTRL_MD_BUBBLE;
        w_state_next = MD_WAIT;
      end else if (w_redir && w_if_stall) begin
        w_ctrl       = CTRL_HOLD;
        w_state_next = IF_DRAIN;
      end else if (w_redir) begin
        w_ctrl        = CTRL_REDIRECT;
        w_apply_redir = 1'b1;
      end else if (w_if_stall) begin
        w_ctrl = CTRL_IF_STALL;
      end else if (load_use) begin
        w_ctrl = CTRL_LOAD_USE;
      end else begin
        w_ctrl = CTRL_RUN;
      end
    end

    if (rst) begin
      w_ctrl = CTRL_HOLD;
    end
  end

  // Any redirect not consumed by a flush this cycle is remembered until one is applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= RUN;
      r_redirect_pending <= 1'b0;
    end else begin
      r_state            <= w_state_next;
      r_redirect_pending <= w_apply_redir ? 1'b0 : (r_redirect_pending | redirect);
    end
  end

  perf_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk     (clk),
    .i_clr   (rst),
    .i_en    (~w_ctrl.pc_load),
    .o_count (stall_cycles)
  );

  perf_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk     (clk),
    .i_clr   (rst),
    .i_en    (w_apply_redir),
    .o_count (flush_events)
  );

  assign pc_load      = w_ctrl.pc_load;
  assign if_id_load   = w_ctrl.if_id_load;
  assign if_id_flush  = w_ctrl.if_id_flush;
  assign id_ex_load   = w_ctrl.id_ex_load;
  assign id_ex_flush  = w_ctrl.id_ex_flush;
  assign ex_mem_load  = w_ctrl.ex_mem_load;
  assign ex_mem_flush = w_ctrl.ex_mem_flush;
  assign mem_wb_load  = w_ctrl.mem_wb_load;
  assign mem_wb_flush = w_ctrl.mem_wb_flush;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Table-driven bench for pipeline_ctrl: per-cycle control check through a scoreboard queue,
// counter model check every cycle, plus a narrow-counter instance to exercise wrap-around.
module tb_pipeline_ctrl;

  localparam logic [8:0] S_RST  = 9'h100;
  localparam logic [8:0] S_IREQ = 9'h080;
  localparam logic [8:0] S_IRSP = 9'h040;
  localparam logic [8:0] S_DREQ = 9'h020;
  localparam logic [8:0] S_DRSP = 9'h010;
  localparam logic [8:0] S_LU   = 9'h008;
  localparam logic [8:0] S_RDR  = 9'h004;
  localparam logic [8:0] S_MDS  = 9'h002;
  localparam logic [8:0] S_MDD  = 9'h001;
  localparam logic [8:0] S_IDLE = 9'h000;

  // {pc, if_id ld/fl, id_ex ld/fl, ex_mem ld/fl, mem_wb ld/fl}
  localparam logic [8:0] K_HOLD  = 9'b0_00_00_00_00;
  localparam logic [8:0] K_RUN   = 9'b1_10_10_10_10;
  localparam logic [8:0] K_MD    = 9'b0_00_00_00_11;
  localparam logic [8:0] K_REDIR = 9'b1_11_11_10_10;
  localparam logic [8:0] K_IF    = 9'b0_11_10_10_10;
  localparam logic [8:0] K_LU    = 9'b0_00_11_10_10;

  typedef struct {
    logic [8:0] stim;
    logic [8:0] exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, imem_req, imem_resp, dmem_req, dmem_resp, load_use, redirect, md_start, md_done;
  logic pc_load, if_id_load, if_id_flush, id_ex_load, id_ex_flush;
  logic ex_mem_load, ex_mem_flush, mem_wb_load, mem_wb_flush;
  logic [31:0] stall_cycles, flush_events;
  logic n_pc, n_ifl, n_iff, n_idl, n_idf, n_exl, n_exf, n_mwl, n_mwf;
  logic [2:0] n_stall, n_flush;

  pipeline_ctrl #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .load_use(load_use),
    .redirect(redirect), .md_start(md_start), .md_done(md_done),
    .pc_load(pc_load), .if_id_load(if_id_load), .if_id_flush(if_id_flush),
    .id_ex_load(id_ex_load), .id_ex_flush(id_ex_flush),
    .ex_mem_load(ex_mem_load), .ex_mem_flush(ex_mem_flush),
    .mem_wb_load(mem_wb_load), .mem_wb_flush(mem_wb_flush),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  pipeline_ctrl #(.CNT_WIDTH(3)) dut_narrow (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .load_use(load_use),
    .redirect(redirect), .md_start(md_start), .md_done(md_done),
    .pc_load(n_pc), .if_id_load(n_ifl), .if_id_flush(n_iff),
    .id_ex_load(n_idl), .id_ex_flush(n_idf),
    .ex_mem_load(n_exl), .ex_mem_flush(n_exf),
    .mem_wb_load(n_mwl), .mem_wb_flush(n_mwf),
    .stall_cycles(n_stall), .flush_events(n_flush)
  );

  int          tests  = 0;
  int          failed = 0;
  int          vec_no = 0;
  logic        cnt_valid = 1'b0;
  logic [31:0] exp_stall = '0;
  logic [31:0] exp_flush = '0;
  logic [8:0]  exp_q[$];
  vec_t        tbl[$];

  function automatic void add(input logic [8:0] stim, input logic [8:0] exp);
    vec_t v;
    v.stim = stim;
    v.exp  = exp;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_counters();
    check($sformatf("stall_cycles@%0d", vec_no), stall_cycles, exp_stall);
    check($sformatf("flush_events@%0d", vec_no), flush_events, exp_flush);
    check($sformatf("stall_cycles_w3@%0d", vec_no), {29'd0, n_stall}, {29'd0, exp_stall[2:0]});
    check($sformatf("flush_events_w3@%0d", vec_no), {29'd0, n_flush}, {29'd0, exp_flush[2:0]});
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [8:0] e;
    logic [8:0] act;
    logic [8:0] act_n;
    @(negedge clk);
    if (cnt_valid) check_counters();
    {rst, imem_req, imem_resp, dmem_req, dmem_resp, load_use, redirect, md_start, md_done} = v.stim;
    exp_q.push_back(v.exp);
    #1;
    e     = exp_q.pop_front();
    act   = {pc_load, if_id_load, if_id_flush, id_ex_load, id_ex_flush,
             ex_mem_load, ex_mem_flush, mem_wb_load, mem_wb_flush};
    act_n = {n_pc, n_ifl, n_iff, n_idl, n_idf, n_exl, n_exf, n_mwl, n_mwf};
    check($sformatf("ctrl@%0d(%s)", vec_no, tag), {23'd0, act}, {23'd0, e});
    check($sformatf("ctrl_w3@%0d(%s)", vec_no, tag), {23'd0, act_n}, {23'd0, e});
    $display("[TB] vec %0d %s in=%b ctrl=%b exp=%b", vec_no, tag, v.stim, act, e);
    if (v.stim[8]) begin
      exp_stall = '0;
      exp_flush = '0;
      cnt_valid = 1'b1;
    end else begin
      if (!e[8]) exp_stall++;
      if (e == K_REDIR) exp_flush++;
    end
    vec_no++;
  endtask

  // mul/div that completes after n wait cycles; stall_cycles must grow by exactly n.
  task automatic md_seq(input int n);
    logic [31:0] base;
    vec_t v;
    base = exp_stall;
    for (int i = 0; i < n; i++) begin
      v.stim = S_MDS; v.exp = K_MD;
      apply(v, "md_seq_wait");
    end
    v.stim = S_MDS | S_MDD; v.exp = K_RUN;
    apply(v, "md_seq_done");
    v.stim = S_IDLE; v.exp = K_RUN;
    apply(v, "md_seq_idle");
    check($sformatf("md_seq(%0d) stall delta", n), stall_cycles, base + 32'(n));
  endtask

  initial begin
    {rst, imem_req, imem_resp, dmem_req, dmem_resp, load_use, redirect, md_start, md_done} = '0;
    rst = 1'b1;

    // reset holds every load/flush low regardless of hazards
    add(S_RST | S_RDR | S_LU, K_HOLD);
    add(S_RST, K_HOLD);
    // idle sweep
    for (int i = 0; i < 10; i++) add((i % 2 == 1) ? (S_IREQ | S_IRSP | S_DREQ | S_DRSP) : S_IDLE, K_RUN);
    // load-use bubble
    add(S_LU, K_LU); add(S_IDLE, K_RUN);
    // mul/div: start at 0, done at 4
    for (int i = 0; i < 4; i++) add(S_MDS, K_MD);
    add(S_MDS | S_MDD, K_RUN); add(S_IDLE, K_RUN);
    // redirect during fetch miss
    add(S_IREQ | S_RDR, K_HOLD); add(S_IREQ, K_HOLD); add(S_IREQ, K_HOLD);
    add(S_IREQ | S_IRSP, K_REDIR); add(S_IDLE, K_RUN);
    // redirect during mem stall
    add(S_DREQ, K_HOLD); add(S_DREQ | S_RDR, K_HOLD); add(S_DREQ, K_HOLD);
    add(S_DREQ | S_DRSP, K_REDIR); add(S_IDLE, K_RUN);
    // plain fetch stall and plain redirect
    add(S_IREQ, K_IF); add(S_RDR, K_REDIR); add(S_IDLE, K_RUN);
    // repeated redirect while pending: one flush only
    add(S_DREQ | S_RDR, K_HOLD); add(S_DREQ | S_RDR, K_HOLD);
    add(S_DREQ | S_DRSP | S_RDR, K_REDIR); add(S_IDLE, K_RUN);
    // redirect captured in MD_WAIT
    add(S_MDS, K_MD); add(S_MDS | S_RDR, K_MD); add(S_MDS | S_MDD, K_REDIR); add(S_IDLE, K_RUN);
    // mem stall freezes MD_WAIT
    add(S_MDS, K_MD); add(S_MDS | S_DREQ, K_HOLD); add(S_MDS | S_DREQ | S_DRSP, K_MD);
    add(S_MDS | S_MDD, K_RUN);
    // priority corners
    add(S_DREQ | S_LU | S_IREQ | S_MDS, K_HOLD);
    add(S_IREQ | S_LU, K_IF);
    add(S_MDS | S_MDD | S_LU, K_LU);
    add(S_MDS | S_IREQ, K_MD); add(S_MDS | S_MDD | S_IREQ, K_IF); add(S_IDLE, K_RUN);
    // IF_DRAIN waits out a mem stall even after imem_resp
    add(S_IREQ | S_RDR, K_HOLD); add(S_IREQ | S_IRSP | S_DREQ, K_HOLD);
    add(S_IREQ | S_IRSP, K_REDIR); add(S_IDLE, K_RUN);
    // reset mid-MD_WAIT
    add(S_MDS, K_MD); add(S_MDS, K_MD); add(S_RST | S_MDS, K_HOLD); add(S_IDLE, K_RUN); add(S_IDLE, K_RUN);
    // reset mid-IF_DRAIN and with a redirect pending: nothing replayed afterwards
    add(S_IREQ | S_RDR, K_HOLD); add(S_RST | S_IREQ, K_HOLD); add(S_IREQ | S_IRSP, K_RUN); add(S_IDLE, K_RUN);
    add(S_DREQ | S_RDR, K_HOLD); add(S_RST, K_HOLD); add(S_IDLE, K_RUN); add(S_IDLE, K_RUN);

    foreach (tbl[i]) apply(tbl[i], "tbl");

    md_seq(1);
    md_seq(2);
    md_seq(7);

    @(negedge clk);
    check_counters();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: CNT_WIDTH, 32, width of the performance counters.
REQ-002 Clock and reset port list: clk in 1, the single clock; rst in 1, synchronous active-high reset sampled on posedge clk.
REQ-003 Fetch port list: imem_req in 1, fetch access outstanding; imem_resp in 1, fetch data valid this cycle.
REQ-004 Memory-stage port list: dmem_req in 1, MEM-stage load/store present; dmem_resp in 1, data access complete this cycle.
REQ-005 Hazard and multicycle port list: load_use in 1, ID depends on a load in EX; redirect in 1, EX resolved taken branch/jump; md_start in 1, EX holds a mul/div; md_done in 1, mul/div result ready.
REQ-006 Control output list: pc_load out 1; if_id_load, if_id_flush, id_ex_load, id_ex_flush, ex_mem_load, ex_mem_flush, mem_wb_load, mem_wb_flush, all out 1.
REQ-007 Counter output list: stall_cycles out CNT_WIDTH, count of cycles with pc_load=0; flush_events out CNT_WIDTH, count of redirect flushes applied.

Function
REQ-008 Flush semantics: a pipeline register clears only when load=1, so every flush SHALL be asserted together with its load; flush=1 with load=0 is forbidden.
REQ-009 The FSM SHALL have three states: RUN, MD_WAIT, IF_DRAIN, plus a sticky redirect_pending bit.
REQ-010 Signal definitions: mem_stall = dmem_req & ~dmem_resp; if_stall = imem_req & ~imem_resp; redir = redirect | redirect_pending.
REQ-011 RUN state, priority order, first match wins.
  - (a) mem_stall: all loads 0; redirect sets redirect_pending.
  - (b) md_start & ~md_done: next state MD_WAIT; pc/if_id/id_ex/ex_mem loads 0; mem_wb load=1 with flush=1.
  - (c) redir & if_stall: next state IF_DRAIN; all loads 0; redirect_pending set.
  - (d) redir: all loads 1; if_id and id_ex flush=1; redirect_pending cleared; flush_events increments.
  - (e) if_stall: pc_load 0; if_id load=1 with flush=1; other loads 1.
  - (f) load_use: pc_load 0, if_id_load 0; id_ex load=1 with flush=1; other loads 1.
  - (g) otherwise: all loads 1, all flushes 0.
REQ-012 MD_WAIT state.
  - Outputs as in REQ-011(b) until md_done=1.
  - On md_done: return to RUN and apply rules (a), then (c)-(g) the same cycle; md_start is ignored in that cycle.
  - mem_stall in MD_WAIT SHALL freeze all loads.
  - redirect in MD_WAIT SHALL set redirect_pending.
REQ-013 IF_DRAIN state.
  - All loads 0 until imem_resp=1.
  - On imem_resp=1 with ~mem_stall: apply REQ-011(d) and return to RUN; the wrong-path instruction is discarded.
REQ-014 redirect_pending SHALL never be lost; redirect while redirect_pending=1 SHALL still produce exactly one flush_events increment.
REQ-015 Latency: all control outputs are combinational from state and inputs in the same cycle; state and counters update on posedge clk.
REQ-016 stall_cycles SHALL increment in every non-reset cycle with pc_load=0.
REQ-017 Both counters SHALL wrap modulo 2^CNT_WIDTH.

Reset
REQ-018 While rst=1: all load and flush outputs 0.
REQ-019 On the posedge with rst=1: state=RUN, redirect_pending=0, counters=0.
REQ-020 rst mid-MD_WAIT or mid-IF_DRAIN SHALL abandon the operation; no flush or count SHALL be issued for it.

Structure
REQ-021 ctrl_state_t (RUN/MD_WAIT/IF_DRAIN) SHALL live in rv32i_types.
REQ-022 A pipe_ctrl_t struct (per-stage load/flush) SHALL live in rv32i_types for reuse by the top level.
REQ-023 One sub-module SHALL be used: perf_counter, instantiated twice (enable input, wrap at CNT_WIDTH, synchronous clear).

Verification
REQ-024 Idle sweep: no hazards for 10 cycles -> all loads 1, flushes 0, stall_cycles=0.
REQ-025 Load-use: load_use=1 for one cycle -> pc_load=0, if_id_load=0, id_ex load+flush=1; stall_cycles=1.
REQ-026 mul/div: md_start at cycle 0, md_done at cycle 4 -> MD_WAIT for cycles 0-3, 4 mem_wb bubbles, release at cycle 4; stall_cycles=4.
REQ-027 Redirect during fetch miss: imem_req=1, imem_resp=0, redirect at cycle 0, imem_resp at cycle 3 -> IF_DRAIN for cycles 0-2; flush of if_id/id_ex at cycle 3; flush_events=1.
REQ-028 Redirect during mem stall: dmem_resp=0 for 3 cycles with redirect at cycle 1 -> all loads 0 for cycles 0-2; flush on the first cycle with dmem_resp=1; flush_events=1.
REQ-029 Reset mid-MD_WAIT: rst at cycle 2 of a mul/div -> outputs 0 during rst; state RUN and counters 0 afterwards.
